// File: rtl/mem_arbiter_if.sv
// Bus bundle between the processor core, the memory arbiter and the memory.
//   instr_*   : fetch request/valid handshake (core side)
//   data_*    : load/store request/valid handshake (core side)
//   mem_*     : single shared memory bus (memory side)
//   bus_error : sticky timeout flag raised by the arbiter
// Modports:
//   slave  : arbiter view (consumes core requests, drives the memory bus)
//   master : environment view (core requesters plus the memory model)
interface mem_arbiter_if;
  logic        instr_req;
  logic [31:0] instr_addr;
  logic [31:0] instr_read;
  logic        instr_valid;

  logic        data_req;
  logic [31:0] data_addr;
  logic [31:0] data_write;
  logic        data_write_enable;
  logic [3:0]  data_be;
  logic [31:0] data_read;
  logic        data_valid;

  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_valid;

  logic        bus_error;

  modport slave (
    input  instr_req, instr_addr,
    output instr_read, instr_valid,
    input  data_req, data_addr, data_write, data_write_enable, data_be,
    output data_read, data_valid,
    output mem_req, mem_addr, mem_wdata, mem_we, mem_be,
    input  mem_rdata, mem_valid,
    output bus_error
  );

  modport master (
    output instr_req, instr_addr,
    input  instr_read, instr_valid,
    output data_req, data_addr, data_write, data_write_enable, data_be,
    input  data_read, data_valid,
    input  mem_req, mem_addr, mem_wdata, mem_we, mem_be,
    output mem_rdata, mem_valid,
    input  bus_error
  );
endinterface

// File: rtl/mem_arbiter.sv
// Serialises the instruction-fetch and load/store request streams onto one
// single-ported memory bus. Fixed priority with starvation protection,
// back-to-back grants on completion and a per-transaction timeout.
// Ports:
//   clk : clock, all state updates on posedge
//   res : asynchronous active-low reset
//   bus : mem_arbiter_if.slave (core handshakes, memory bus, bus_error)
module mem_arbiter #(
  parameter bit          DataPriority  = 1'b1,
  parameter int unsigned MaxStarve     = 4,
  parameter int unsigned TimeoutCycles = 64
) (
  input  logic         clk,
  input  logic         res,
  mem_arbiter_if.slave bus
);

  localparam logic [3:0] MaxS    = 4'(MaxStarve);
  localparam logic [7:0] TmoLast = 8'(TimeoutCycles - 1);

  typedef enum logic [1:0] {StIdle, StBusyI, StBusyD} state_e;

  state_e      state_q;
  logic [3:0]  starve_q;
  logic [7:0]  tmo_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        we_q;
  logic [3:0]  be_q;
  logic        err_q;

  logic busy, tmo, done;
  logic elig_i, elig_d;
  logic grant_i, grant_d;
  logic prio_grant, other_elig;

  assign busy = (state_q != StIdle);
  assign tmo  = busy && !bus.mem_valid && (tmo_q == TmoLast);
  assign done = busy && (bus.mem_valid || tmo);

  // The completing port still holds its req this cycle, so it is excluded.
  assign elig_i = bus.instr_req && ((state_q == StIdle) || ((state_q == StBusyD) && done));
  assign elig_d = bus.data_req  && ((state_q == StIdle) || ((state_q == StBusyI) && done));

  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (elig_i && elig_d) begin
      if (starve_q == MaxS) begin
        grant_i = DataPriority;
        grant_d = !DataPriority;
      end else begin
        grant_i = !DataPriority;
        grant_d = DataPriority;
      end
    end else begin
      grant_i = elig_i;
      grant_d = elig_d;
    end
  end

  assign prio_grant = DataPriority ? grant_d : grant_i;
  assign other_elig = DataPriority ? elig_i : elig_d;

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q  <= StIdle;
      starve_q <= '0;
      tmo_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      be_q     <= '0;
      err_q    <= 1'b0;
    end else begin
      // Not done while busy implies mem_valid is low.
      if (busy && !done) begin
        tmo_q <= tmo_q + 8'd1;
      end
      if (tmo) begin
        err_q <= 1'b1;
      end
      if (!busy || done) begin
        if (grant_i) begin
          state_q <= StBusyI;
          addr_q  <= bus.instr_addr;
          wdata_q <= '0;
          we_q    <= 1'b0;
          be_q    <= 4'hF;
        end else if (grant_d) begin
          state_q <= StBusyD;
          addr_q  <= bus.data_addr;
          wdata_q <= bus.data_write;
          we_q    <= bus.data_write_enable;
          be_q    <= bus.data_be;
        end else begin
          state_q <= StIdle;
        end
        if (grant_i || grant_d) begin
          tmo_q <= '0;
          if (prio_grant && other_elig) begin
            starve_q <= (starve_q == MaxS) ? MaxS : starve_q + 4'd1;
          end else begin
            starve_q <= '0;
          end
        end
      end
    end
  end

  // mem_req follows the registered state, so reset drops it without a clock edge.
  assign bus.mem_req   = busy;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_be    = be_q;
  assign bus.bus_error = err_q;

  // A timeout completes the transaction with zero read data.
  assign bus.instr_valid = done && (state_q == StBusyI);
  assign bus.data_valid  = done && (state_q == StBusyD);
  assign bus.instr_read  = (bus.instr_valid && bus.mem_valid) ? bus.mem_rdata : '0;
  assign bus.data_read   = (bus.data_valid && bus.mem_valid) ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random
// traffic, all compared cycle by cycle against a transaction-level model.
module tb_mem_arbiter;
  localparam bit Prio = 1'b1;
  localparam int MaxS = 4;
  localparam int Tmo  = 8;

  logic clk = 1'b0;
  logic res = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if bus ();

  mem_arbiter #(
    .DataPriority (Prio),
    .MaxStarve    (MaxS),
    .TimeoutCycles(Tmo)
  ) dut (
    .clk(clk),
    .res(res),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the bus (0 none, 1 fetch, 2 data), how long the
  // current transaction has waited, starvation count and the latched request.
  int          m_owner, m_tcnt, m_starve;
  logic [31:0] m_addr, m_wdata;
  logic        m_we, m_err;
  logic [3:0]  m_be;
  bit          exp_iv, exp_dv;

  int          mem_mode;  // 0: answer at fixed age, 1: random, 2: manual
  int          mem_lat;
  int          dead;
  logic [31:0] fix_rdata;
  int          iv_cnt = 0;
  int          dv_cnt = 0;
  int          n0;

  always @(negedge clk) begin
    if (bus.instr_valid === 1'b1) iv_cnt++;
    if (bus.data_valid === 1'b1) dv_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner  = 0;
    m_tcnt   = 0;
    m_starve = 0;
    m_addr   = '0;
    m_wdata  = '0;
    m_we     = 1'b0;
    m_be     = '0;
    m_err    = 1'b0;
    exp_iv   = 0;
    exp_dv   = 0;
  endtask

  task automatic check_model();
    logic [31:0] rd;
    bit done;
    done   = (m_owner != 0) && (bus.mem_valid || (m_tcnt == Tmo - 1));
    rd     = bus.mem_valid ? bus.mem_rdata : 32'h0;
    exp_iv = done && (m_owner == 1);
    exp_dv = done && (m_owner == 2);
    chk("mem_req", bus.mem_req, m_owner != 0);
    chk("mem_addr", bus.mem_addr, m_addr);
    chk("mem_wdata", bus.mem_wdata, m_wdata);
    chk("mem_we", bus.mem_we, m_we);
    chk("mem_be", bus.mem_be, m_be);
    chk("bus_error", bus.bus_error, m_err);
    chk("instr_valid", bus.instr_valid, exp_iv);
    chk("data_valid", bus.data_valid, exp_dv);
    if (exp_iv) chk("instr_read", bus.instr_read, rd);
    else if (m_owner == 2) chk("instr_read_idle", bus.instr_read, 32'h0);
    if (exp_dv) chk("data_read", bus.data_read, rd);
    else if (m_owner == 1) chk("data_read_idle", bus.data_read, 32'h0);
  endtask

  task automatic model_step();
    bit done, ei, ed;
    int win, pr, np;
    pr   = Prio ? 2 : 1;
    np   = 3 - pr;
    done = (m_owner != 0) && (bus.mem_valid || (m_tcnt == Tmo - 1));
    if (m_owner != 0 && !done) begin
      m_tcnt++;
      return;
    end
    if (m_owner != 0 && !bus.mem_valid) m_err = 1'b1;
    ei  = bus.instr_req && (m_owner != 1);
    ed  = bus.data_req && (m_owner != 2);
    win = 0;
    if (ei && ed) win = (m_starve == MaxS) ? np : pr;
    else if (ei) win = 1;
    else if (ed) win = 2;
    if (win != 0) begin
      if (win == pr && ((pr == 2) ? ei : ed)) begin
        if (m_starve < MaxS) m_starve++;
      end else begin
        m_starve = 0;
      end
      m_tcnt = 0;
      if (win == 1) begin
        m_addr = bus.instr_addr; m_wdata = '0; m_we = 1'b0; m_be = 4'hF;
      end else begin
        m_addr = bus.data_addr; m_wdata = bus.data_write;
        m_we = bus.data_write_enable; m_be = bus.data_be;
      end
    end
    m_owner = win;
  endtask

  // One clock: drive memory, check at negedge, advance model, retire requests.
  task automatic tick();
    if (mem_mode == 0) begin
      bus.mem_valid = (m_owner != 0) && (m_tcnt == mem_lat);
      bus.mem_rdata = fix_rdata;
    end else if (mem_mode == 1) begin
      bus.mem_valid = (dead == 0) && ($urandom_range(0, 2) == 0);
      bus.mem_rdata = $urandom;
    end
    @(negedge clk);
    check_model();
    model_step();
    @(posedge clk);
    #1;
    if (exp_iv) bus.instr_req = 1'b0;
    if (exp_dv) bus.data_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.instr_req = 1'b0; bus.instr_addr = '0;
    bus.data_req = 1'b0; bus.data_addr = '0; bus.data_write = '0;
    bus.data_write_enable = 1'b0; bus.data_be = '0;
    bus.mem_rdata = '0; bus.mem_valid = 1'b0;
    mem_mode = 2; mem_lat = -1; dead = 0; fix_rdata = '0;
    model_reset();

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_model();
    @(posedge clk);
    #1;
    res = 1'b1;

    // Fetch only, memory answers two cycles after mem_req.
    mem_mode = 0; mem_lat = 2; fix_rdata = 32'h0000_0013;
    bus.instr_req = 1'b1; bus.instr_addr = 32'h100;
    tick();
    chk("t1_req", bus.mem_req, 1);
    chk("t1_addr", bus.mem_addr, 32'h100);
    chk("t1_we", bus.mem_we, 0);
    chk("t1_be", bus.mem_be, 4'hF);
    n0 = iv_cnt;
    repeat (3) tick();
    chk("t1_pulses", iv_cnt - n0, 1);
    chk("t1_req_after", bus.mem_req, 0);
    tick();

    // Simultaneous store and fetch: data first, then back-to-back fetch.
    mem_lat = 1;
    bus.data_req = 1'b1; bus.data_addr = 32'h2000; bus.data_write = 32'hABCD;
    bus.data_write_enable = 1'b1; bus.data_be = 4'h3;
    bus.instr_req = 1'b1; bus.instr_addr = 32'h104;
    tick();
    chk("t2_addr", bus.mem_addr, 32'h2000);
    chk("t2_we", bus.mem_we, 1);
    chk("t2_be", bus.mem_be, 4'h3);
    chk("t2_wdata", bus.mem_wdata, 32'hABCD);
    repeat (2) tick();
    chk("t2_b2b_req", bus.mem_req, 1);
    chk("t2_b2b_addr", bus.mem_addr, 32'h104);
    chk("t2_b2b_we", bus.mem_we, 0);
    repeat (3) tick();

    // Starvation: four data wins on collisions, then the fetch gets one.
    mem_lat = 0;
    for (int r = 0; r < 6; r++) begin
      bus.data_req = 1'b1; bus.data_addr = 32'h3000 + 32'(r * 16);
      bus.data_write_enable = 1'b0; bus.data_be = 4'hF;
      bus.instr_req = 1'b1; bus.instr_addr = 32'h200;
      tick();
      if (r == 4) begin
        chk("starve_fetch_grant", bus.mem_addr, 32'h200);
        repeat (3) tick();
      end else begin
        chk("prio_data_grant", bus.mem_addr, 32'h3000 + 32'(r * 16));
        bus.instr_req = 1'b0;
        tick();
      end
    end

    // Timeout: memory never answers.
    mem_lat = -1;
    bus.instr_req = 1'b1; bus.instr_addr = 32'h400;
    tick();
    n0 = iv_cnt;
    repeat (7) tick();
    chk("t4_no_early_valid", iv_cnt - n0, 0);
    chk("t4_valid", bus.instr_valid, 1);
    chk("t4_read_zero", bus.instr_read, 0);
    tick();
    chk("t4_err", bus.bus_error, 1);
    repeat (3) tick();
    chk("t4_err_sticky", bus.bus_error, 1);

    // Reset in the middle of a store.
    bus.data_req = 1'b1; bus.data_addr = 32'h500; bus.data_write = 32'h55;
    bus.data_write_enable = 1'b1; bus.data_be = 4'hF;
    tick();
    tick();
    mem_mode = 2; bus.mem_valid = 1'b1; n0 = dv_cnt;
    #2;
    res = 1'b0;
    #1;
    chk("t5_req_async", bus.mem_req, 0);
    chk("t5_no_dvalid", bus.data_valid, 0);
    model_reset();
    bus.data_req = 1'b0; bus.mem_valid = 1'b0;
    @(posedge clk);
    #1;
    res = 1'b1;
    chk("t5_err_cleared", bus.bus_error, 0);
    chk("t5_no_pulse", dv_cnt - n0, 0);
    tick();
    chk("t5_idle", bus.mem_req, 0);

    // Spurious mem_valid in idle, then a fetch whose req drops mid-flight.
    bus.mem_valid = 1'b1; bus.mem_rdata = 32'hDEAD;
    n0 = iv_cnt + dv_cnt;
    repeat (2) tick();
    chk("t6_spurious", iv_cnt + dv_cnt - n0, 0);
    bus.mem_valid = 1'b0;
    bus.instr_req = 1'b1; bus.instr_addr = 32'h600;
    tick();
    bus.instr_req = 1'b0;
    mem_mode = 0; mem_lat = 2; fix_rdata = 32'h600D;
    n0 = iv_cnt;
    repeat (4) tick();
    chk("t6_dropped_pulse", iv_cnt - n0, 1);

    // Random traffic, including stalls long enough to time out.
    mem_mode = 1;
    for (int c = 0; c < 1500; c++) begin
      if (dead > 0) dead--;
      else if ($urandom_range(0, 59) == 0) dead = $urandom_range(6, 12);
      if (!bus.instr_req && $urandom_range(0, 2) == 0) begin
        bus.instr_req = 1'b1; bus.instr_addr = $urandom & 32'hFFFF_FFFC;
      end else if (bus.instr_req && $urandom_range(0, 63) == 0) begin
        bus.instr_req = 1'b0;
      end
      if (!bus.data_req && $urandom_range(0, 2) == 0) begin
        bus.data_req = 1'b1; bus.data_addr = $urandom; bus.data_write = $urandom;
        bus.data_write_enable = 1'($urandom_range(0, 1));
        bus.data_be = 4'($urandom_range(0, 15));
      end else if (bus.data_req && $urandom_range(0, 63) == 0) begin
        bus.data_req = 1'b0;
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-ported memory bus between the processor's instruction-fetch port and its load/store data port.
- Sits between the proc core and the memory model/BRAM wrapper.
- The core keeps its existing instr_*/data_* request/valid handshakes; this block serialises the two streams onto one mem_* bus.
- Provides fixed priority with starvation protection, back-to-back grants and a per-transaction timeout.

Parameters:
- DataPriority, 1, 1 = data port wins simultaneous requests; 0 = instruction port wins.
- MaxStarve, 4, number of consecutive grants to the priority port while the other port waits; after this many, the other port is granted once. Range 1..15.
- TimeoutCycles, 64, number of busy cycles without mem_valid before the transaction is aborted. Range 2..255.

Ports:
- clk  in  1  clock, all state updates on posedge.
- res  in  1  reset, asynchronous, active-low.
- instr_req  in  1  fetch request; held until instr_valid.
- instr_addr  in  32  fetch address; stable while instr_req is high.
- instr_read  out  32  fetch data; meaningful only when instr_valid is high.
- instr_valid  out  1  one-cycle fetch completion pulse.
- data_req  in  1  load/store request; held until data_valid.
- data_addr  in  32  load/store address.
- data_write  in  32  store data.
- data_write_enable  in  1  1 = store.
- data_be  in  4  byte enables.
- data_read  out  32  load data; meaningful only when data_valid is high.
- data_valid  out  1  one-cycle load/store completion pulse.
- mem_req  out  1  memory request, high for the whole transaction.
- mem_addr  out  32  registered address.
- mem_wdata  out  32  registered store data.
- mem_we  out  1  registered write enable (0 for fetches).
- mem_be  out  4  registered byte enables (4'b1111 for fetches).
- mem_rdata  in  32  memory read data.
- mem_valid  in  1  memory completion.
- bus_error  out  1  sticky timeout flag, cleared only by reset.

Behaviour:
- Reset (res low, asynchronous):
  - state = IDLE.
  - mem_req, mem_we, instr_valid, data_valid, bus_error = 0.
  - mem_addr, mem_wdata = 0; mem_be = 0.
  - starve and timeout counters = 0.
- Reset asserted mid-transaction aborts it immediately: mem_req drops asynchronously and no valid pulse is issued.
- States: IDLE, BUSY_I, BUSY_D.
- Arbitration (evaluated in IDLE, and in the completion cycle of BUSY_*):
  - Only one requester eligible: grant it.
  - Both eligible: grant the priority port, unless starve == MaxStarve, in which case grant the non-priority port.
- Starve counter:
  - Increments on each priority-port grant made while the other port is requesting.
  - Cleared on any non-priority grant, or when the other port is not requesting at the time of a grant.
  - Saturates at MaxStarve.
- On grant: mem_addr, mem_wdata, mem_we and mem_be are registered from the granted port; mem_req = 1 from the next cycle.
  - Latency: req seen in IDLE at cycle N → mem_req high at N+1.
- Busy state:
  - Timeout counter clears on entry and increments each cycle mem_valid is low.
  - Cycle with mem_valid = 1: the owning port's *_valid = 1 and *_read = mem_rdata, combinationally in the same cycle.
  - The other port's *_valid stays 0 and its *_read reads 0.
- Completion cycle:
  - The completing port is excluded from arbitration, because its req is still high this cycle.
  - If the other port is requesting, go directly to its BUSY state (back-to-back, no IDLE bubble, mem_req stays high with new registered fields).
  - Otherwise go to IDLE and mem_req = 0.
- Timeout (counter reaches TimeoutCycles-1 with mem_valid low):
  - Owning port gets *_valid = 1 with *_read = 32'h0.
  - bus_error is set; next state follows the completion rule above.
- mem_valid asserted while in IDLE is ignored.
- A requester dropping req mid-transaction does not abort it; the valid pulse is still issued.

Test Plan:
- Fetch only: instr_req=1, instr_addr=0x100; memory answers 2 cycles after mem_req → mem_addr=0x100, mem_we=0, mem_be=4'hF; instr_valid pulses once with instr_read=mem_rdata=0x00000013; mem_req=0 the next cycle.
- Simultaneous requests, DataPriority=1: data store to 0x2000 (be=4'h3, wdata=0xABCD) and fetch to 0x104 raised together → data transaction first; on its mem_valid cycle the arbiter switches to the fetch with mem_req held high and mem_addr=0x104 the next cycle.
- Starvation, MaxStarve=4: data_req held continuously with instant mem_valid, instr_req held → exactly 4 data grants, then 1 fetch grant, then the pattern repeats.
- Timeout, TimeoutCycles=8: fetch issued, mem_valid never asserted → instr_valid=1 with instr_read=0 on the 8th busy cycle; bus_error=1 and stays 1.
- Reset mid-transaction: res driven low during BUSY_D → mem_req=0 without waiting for a clock edge, no data_valid; after release with no requests pending, block is in IDLE with bus_error=0.
- Spurious mem_valid in IDLE and a requester dropping req mid-transaction → no valid pulses from the spurious mem_valid; the dropped-request transaction still completes with a single valid pulse.
